ext_slt_host: RTL and testbench
===============================

EXT_SLT_HOST -- requirements
Module: ext_slt_host

Interface
REQ-001 Parameter: STROBE_CYCLES, default 2, sets the number of SLT_CLOCK cycles RDn/WEn stay low per bus cycle (legal range 1..7).
REQ-002 SLT_CLOCK  input  1  sole clock; all state changes on the rising edge.
REQ-003 SLT_RESETn  input  1  asynchronous active-low reset.
REQ-004 CMD_VALID  input  1  command request.
REQ-005 CMD_READY  output  1  command accepted when CMD_VALID & CMD_READY.
REQ-006 CMD_WR  input  1  1=write, 0=read.
REQ-007 CMD_SUBSLOT  input  2  target subslot for the page addressed by CMD_ADDR[15:14].
REQ-008 CMD_ADDR  input  16  target address.
REQ-009 CMD_WDATA  input  8  write data.
REQ-010 RSP_VALID  output  1  one-cycle completion pulse.
REQ-011 RSP_RDATA  output  8  read data, valid with RSP_VALID.
REQ-012 RSP_ERR  output  1  subslot verify failure, valid with RSP_VALID.
REQ-013 SLT_A  output  16  slot address bus.
REQ-014 SLT_D  inout  8  slot data bus, driven only during write cycles.
REQ-015 SLT_SLTSLn  output  1  active-low slot select.
REQ-016 SLT_RDn / SLT_WEn  output  1 each  active-low strobes.

Function
REQ-017 Every bus cycle SHALL be STROBE_CYCLES+2 clocks: T1 address valid and SLTSLn low; strobe low for STROBE_CYCLES clocks; final clock strobe high, SLTSLn still low; SLTSLn high after.
REQ-018 Read data SHALL be sampled on the rising edge ending the last strobe-low clock; SLT_D driven from T1 through the final clock of write cycles only.
REQ-019 FSM states: IDLE, SEL_RD, SEL_WR, VERIFY, ACCESS, RESP; CMD_READY high only in IDLE.
REQ-020 On acceptance, if SHADOW_VALID=0 go SEL_RD: read FFFFh, store bitwise inverse of data into an 8-bit shadow, set SHADOW_VALID.
REQ-021 If shadow field for page p (bits 2p+1:2p) equals CMD_SUBSLOT go directly to ACCESS; otherwise SEL_WR writes FFFFh with only that field replaced, shadow updated to the written value.
REQ-022 VERIFY reads FFFFh; data SHALL equal ~shadow, else RSP_ERR=1, SHADOW_VALID cleared, ACCESS skipped.
REQ-023 ACCESS performs the command's read or write at CMD_ADDR; RSP_VALID pulses in RESP, the clock after the last bus-cycle clock, then return to IDLE.
REQ-024 Command fields SHALL be latched at acceptance; later input changes are ignored.
REQ-025 CMD_ADDR=FFFFh: no select sequence; direct access; a write sets shadow to CMD_WDATA, a read sets shadow to ~data; SHADOW_VALID set.
REQ-026 Idle bus: SLT_A=0000h, SLT_D high-Z, SLTSLn/RDn/WEn=1.

Reset
REQ-027 SLT_RESETn low SHALL immediately force IDLE, bus idle values, CMD_READY=1, RSP_VALID=0, RSP_ERR=0, RSP_RDATA=00h, shadow=00h, SHADOW_VALID=0, including mid-cycle; the aborted command produces no response.

Configuration
REQ-028 Macro EXT_SLT_HOST_VERIFY_EN: defined -> VERIFY executes after every SEL_WR; undefined -> SEL_WR proceeds straight to ACCESS and RSP_ERR is constant 0.

Structure
REQ-029 Package ext_slt_pkg SHALL hold the FSM state enum, SUBREG_ADDR=16'hFFFF, and bus idle constants.
REQ-030 Sub-module ext_slt_buscyc SHALL implement one bus cycle (start/done handshake, address, wr, wdata, rdata) per REQ-017/018.

Verification
REQ-031 After reset, read 4000h subslot 2, bus model FFFFh register=00h -> RD FFFF returns FFh, WR FFFF=08h, VERIFY returns F7h, RD 4000h; RSP_ERR=0 (16 clocks of bus activity at STROBE_CYCLES=2).
REQ-032 Repeat read 4000h subslot 2 -> only one 4-clock ACCESS cycle, no FFFFh access.
REQ-033 Model corrupts readback (returns FFh after WR 08h) -> RSP_VALID with RSP_ERR=1, no 4000h access, next command restarts with SEL_RD.
REQ-034 Write C000h subslot 3 data 5Ah -> WR FFFF with bits 7:6=11b, then WR C000h with SLT_D=5Ah for all 4 clocks.
REQ-035 Assert SLT_RESETn low during SEL_WR strobe -> SLTSLn/WEn high and SLT_D high-Z same instant, no RSP_VALID, next command begins with SEL_RD.
REQ-036 Write FFFFh data E4h, then read 8000h subslot 2 -> no select sequence, single ACCESS cycle.

Source files
------------

// File: rtl/ext_slt_pkg.sv
// Shared definitions for the external slot host: FSM states, the
// subslot-register address, bus idle values and subslot-field helpers.
package ext_slt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEL_RD,
        ST_SEL_WR,
        ST_VERIFY,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam logic [15:0] SUBREG_ADDR = 16'hFFFF;
    localparam logic [15:0] IDLE_ADDR   = 16'h0000;
    localparam logic        IDLE_STROBE = 1'b1;

    // Two-bit subslot field of the shadow byte belonging to a 16 KiB page
    function automatic logic [1:0] get_field(input logic [7:0] shadow, input logic [1:0] page);
        return shadow[{page, 1'b0} +: 2];
    endfunction

    // Shadow byte with the field of one page replaced
    function automatic logic [7:0] set_field(input logic [7:0] shadow, input logic [1:0] page,
                                             input logic [1:0] sub);
        logic [7:0] r;
        r = shadow;
        r[{page, 1'b0} +: 2] = sub;
        return r;
    endfunction

endpackage

// File: rtl/ext_slt_buscyc.sv
// One slot bus cycle: T1 (select + address), STROBE_CYCLES strobe-low clocks,
// one final strobe-high clock with select still low. done is high during the
// final clock; read data is captured on the edge ending the last strobe clock.
module ext_slt_buscyc
    import ext_slt_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    input  logic [7:0]  din,
    output logic        idle,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [15:0] a,
    output logic [7:0]  dout,
    output logic        d_oe,
    output logic        sltsl_n,
    output logic        rd_n,
    output logic        we_n
);

    localparam logic [3:0] LAST      = 4'(STROBE_CYCLES + 2);
    localparam logic [3:0] STRB_LAST = 4'(STROBE_CYCLES + 1);

    // phase 0 = idle, 1 = T1, 2..STRB_LAST = strobe low, LAST = final clock
    logic [3:0]  phase;
    logic        wr_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic        strobe;

    // Phase sequencing and capture of the cycle's address/direction/data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (phase == 4'd0) begin
            if (start) begin
                phase   <= 4'd1;
                wr_q    <= wr;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
        end else if (phase == LAST) begin
            phase <= '0;
        end else begin
            phase <= phase + 4'd1;
        end
    end

    // Read data sampled on the edge that ends the last strobe-low clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (phase == STRB_LAST && !wr_q) begin
            rdata <= din;
        end
    end

    assign strobe  = (phase >= 4'd2) && (phase <= STRB_LAST);
    assign idle    = (phase == 4'd0);
    assign done    = (phase == LAST);
    assign a       = idle ? IDLE_ADDR : addr_q;
    assign sltsl_n = idle;
    assign rd_n    = (strobe && !wr_q) ? 1'b0 : IDLE_STROBE;
    assign we_n    = (strobe && wr_q) ? 1'b0 : IDLE_STROBE;
    assign d_oe    = !idle && wr_q;
    assign dout    = wdata_q;

endmodule

// File: rtl/ext_slt_host.sv
// Slot host: accepts read/write commands, makes sure the requested subslot is
// selected for the target page via the FFFFh subslot register (kept in a shadow
// copy), then performs the access. Optional readback check of the subslot
// register after each select write is built when EXT_SLT_HOST_VERIFY_EN is defined.
module ext_slt_host
    import ext_slt_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        SLT_CLOCK,
    input  logic        SLT_RESETn,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic        CMD_WR,
    input  logic [1:0]  CMD_SUBSLOT,
    input  logic [15:0] CMD_ADDR,
    input  logic [7:0]  CMD_WDATA,
    output logic        RSP_VALID,
    output logic [7:0]  RSP_RDATA,
    output logic        RSP_ERR,
    output logic [15:0] SLT_A,
    inout  wire  [7:0]  SLT_D,
    output logic        SLT_SLTSLn,
    output logic        SLT_RDn,
    output logic        SLT_WEn
);

    state_t      state;
    logic        wr_q;
    logic [1:0]  sub_q;
    logic [15:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  shadow;
    logic        shadow_valid;
    logic [7:0]  rsp_rdata;
    logic [7:0]  sel_value;

    logic        bus_start;
    logic        bus_wr;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_idle;
    logic        bus_done;
    logic [7:0]  bus_rdata;
    logic [7:0]  bus_dout;
    logic        bus_oe;

`ifdef EXT_SLT_HOST_VERIFY_EN
    logic rsp_err;
    assign RSP_ERR = rsp_err;
`else
    assign RSP_ERR = 1'b0;
`endif

    assign sel_value = set_field(shadow, addr_q[15:14], sub_q);

    // Bus request for the current state: subslot register unless accessing
    always_comb begin
        bus_addr  = SUBREG_ADDR;
        bus_wr    = 1'b0;
        bus_wdata = sel_value;
        case (state)
            ST_SEL_WR: bus_wr = 1'b1;
            ST_ACCESS: begin
                bus_addr  = addr_q;
                bus_wr    = wr_q;
                bus_wdata = wdata_q;
            end
            default: ;
        endcase
    end

    // A bus state's cycle starts on its first clock; the state changes with done
    assign bus_start = bus_idle && (state == ST_SEL_RD || state == ST_SEL_WR ||
                                    state == ST_VERIFY || state == ST_ACCESS);

    // Command sequencing, shadow maintenance and response capture
    always_ff @(posedge SLT_CLOCK or negedge SLT_RESETn) begin
        if (!SLT_RESETn) begin
            state        <= ST_IDLE;
            wr_q         <= 1'b0;
            sub_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            shadow       <= '0;
            shadow_valid <= 1'b0;
            rsp_rdata    <= '0;
`ifdef EXT_SLT_HOST_VERIFY_EN
            rsp_err      <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: if (CMD_VALID) begin
                    wr_q    <= CMD_WR;
                    sub_q   <= CMD_SUBSLOT;
                    addr_q  <= CMD_ADDR;
                    wdata_q <= CMD_WDATA;
`ifdef EXT_SLT_HOST_VERIFY_EN
                    rsp_err <= 1'b0;
`endif
                    if (CMD_ADDR == SUBREG_ADDR)
                        state <= ST_ACCESS;
                    else if (!shadow_valid)
                        state <= ST_SEL_RD;
                    else if (get_field(shadow, CMD_ADDR[15:14]) == CMD_SUBSLOT)
                        state <= ST_ACCESS;
                    else
                        state <= ST_SEL_WR;
                end
                ST_SEL_RD: if (bus_done) begin
                    shadow       <= ~bus_rdata;
                    shadow_valid <= 1'b1;
                    state <= (get_field(~bus_rdata, addr_q[15:14]) == sub_q) ? ST_ACCESS : ST_SEL_WR;
                end
                ST_SEL_WR: if (bus_done) begin
                    shadow <= sel_value;
`ifdef EXT_SLT_HOST_VERIFY_EN
                    state  <= ST_VERIFY;
`else
                    state  <= ST_ACCESS;
`endif
                end
`ifdef EXT_SLT_HOST_VERIFY_EN
                ST_VERIFY: if (bus_done) begin
                    if (bus_rdata == ~shadow) begin
                        state <= ST_ACCESS;
                    end else begin
                        rsp_err      <= 1'b1;
                        shadow_valid <= 1'b0;
                        state        <= ST_RESP;
                    end
                end
`endif
                ST_ACCESS: if (bus_done) begin
                    if (!wr_q)
                        rsp_rdata <= bus_rdata;
                    if (addr_q == SUBREG_ADDR) begin
                        shadow       <= wr_q ? wdata_q : ~bus_rdata;
                        shadow_valid <= 1'b1;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign CMD_READY = (state == ST_IDLE);
    assign RSP_VALID = (state == ST_RESP);
    assign RSP_RDATA = rsp_rdata;

    ext_slt_buscyc #(.STROBE_CYCLES(STROBE_CYCLES)) u_bus (
        .clk     (SLT_CLOCK),
        .rst_n   (SLT_RESETn),
        .start   (bus_start),
        .wr      (bus_wr),
        .addr    (bus_addr),
        .wdata   (bus_wdata),
        .din     (SLT_D),
        .idle    (bus_idle),
        .done    (bus_done),
        .rdata   (bus_rdata),
        .a       (SLT_A),
        .dout    (bus_dout),
        .d_oe    (bus_oe),
        .sltsl_n (SLT_SLTSLn),
        .rd_n    (SLT_RDn),
        .we_n    (SLT_WEn)
    );

    assign SLT_D = bus_oe ? bus_dout : 'z;

endmodule

// File: tb/tb_ext_slt_host.sv
// Directed bench for ext_slt_host with a small slot model: FFFFh reads return
// the inverted subslot register (or FFh when corrupted), other reads return
// addr[15:8]^addr[7:0]^A5h. Bus cycles are logged on the falling edge.
`timescale 1ns/1ps
module tb_ext_slt_host;

`ifdef EXT_SLT_HOST_VERIFY_EN
    localparam int unsigned VER = 1;
`else
    localparam int unsigned VER = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_wr = 1'b0;
    logic [1:0]  cmd_sub = '0;
    logic [15:0] cmd_addr = '0;
    logic [7:0]  cmd_wdata = '0;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        rsp_err;
    logic [15:0] slt_a;
    wire  [7:0]  slt_d;
    logic        slt_sltsln;
    logic        slt_rdn;
    logic        slt_wen;

    always #5 clk = ~clk;

    ext_slt_host #(.STROBE_CYCLES(2)) dut (
        .SLT_CLOCK   (clk),
        .SLT_RESETn  (rst_n),
        .CMD_VALID   (cmd_valid),
        .CMD_READY   (cmd_ready),
        .CMD_WR      (cmd_wr),
        .CMD_SUBSLOT (cmd_sub),
        .CMD_ADDR    (cmd_addr),
        .CMD_WDATA   (cmd_wdata),
        .RSP_VALID   (rsp_valid),
        .RSP_RDATA   (rsp_rdata),
        .RSP_ERR     (rsp_err),
        .SLT_A       (slt_a),
        .SLT_D       (slt_d),
        .SLT_SLTSLn  (slt_sltsln),
        .SLT_RDn     (slt_rdn),
        .SLT_WEn     (slt_wen)
    );

    // Slot model
    logic [7:0]  sub_reg = 8'h00;
    logic        corrupt = 1'b0;
    logic [15:0] last_wa = '0;
    logic [7:0]  last_wd = '0;
    logic        model_oe;
    logic [7:0]  model_d;

    assign model_oe = !slt_sltsln && !slt_rdn;
    assign model_d  = (slt_a == 16'hFFFF) ? (corrupt ? 8'hFF : ~sub_reg)
                                          : (slt_a[15:8] ^ slt_a[7:0] ^ 8'hA5);
    assign slt_d    = model_oe ? model_d : 'z;

    // Slot-side write capture while the write strobe is low
    always @(negedge clk) begin
        if (!slt_sltsln && !slt_wen) begin
            if (slt_a == 16'hFFFF) sub_reg <= slt_d;
            else begin
                last_wa <= slt_a;
                last_wd <= slt_d;
            end
        end
    end

    // Bus cycle and response logger
    logic [15:0] log_addr [0:127];
    logic        log_wr   [0:127];
    logic [7:0]  log_d    [0:127];
    logic        log_dst  [0:127];
    int unsigned log_len  [0:127];
    int unsigned log_strb [0:127];
    int unsigned n_cyc = 0, act_clocks = 0, rsp_cnt = 0;
    int unsigned cur_len = 0, cur_strb = 0;
    logic [15:0] cur_addr = '0;
    logic        cur_wr = 1'b0, cur_dst = 1'b1;
    logic [7:0]  cur_d = '0;
    logic        last_err = 1'b0;
    logic [7:0]  last_rdata = '0;

    always @(negedge clk) begin
        if (!slt_sltsln) begin
            act_clocks <= act_clocks + 1;
            cur_len    <= cur_len + 1;
            cur_strb   <= ((cur_len == 0) ? 0 : cur_strb) + ((!slt_rdn || !slt_wen) ? 1 : 0);
            cur_wr     <= ((cur_len == 0) ? 1'b0 : cur_wr) | !slt_wen;
            if (cur_len == 0) begin
                cur_addr <= slt_a;
                cur_d    <= slt_d;
                cur_dst  <= 1'b1;
            end else begin
                cur_dst  <= cur_dst && (slt_d === cur_d) && (slt_a == cur_addr);
            end
        end else if (cur_len != 0) begin
            log_addr[n_cyc % 128] <= cur_addr;
            log_wr[n_cyc % 128]   <= cur_wr;
            log_d[n_cyc % 128]    <= cur_d;
            log_dst[n_cyc % 128]  <= cur_dst;
            log_len[n_cyc % 128]  <= cur_len;
            log_strb[n_cyc % 128] <= cur_strb;
            n_cyc   <= n_cyc + 1;
            cur_len <= 0;
        end
        if (rsp_valid) begin
            rsp_cnt    <= rsp_cnt + 1;
            last_err   <= rsp_err;
            last_rdata <= rsp_rdata;
        end
    end

    int unsigned n_checks = 0, n_errors = 0;
    int unsigned b_cyc = 0, b_rsp = 0, b_clk = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [1:0] sub, input logic [15:0] addr,
                         input logic [7:0] wd);
        int unsigned t = 0;
        while (!cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("ready_wait", {31'd0, cmd_ready}, 1);
        cmd_valid = 1'b1;
        cmd_wr    = wr;
        cmd_sub   = sub;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(posedge clk);
        #1;
        // scramble the command inputs: the host must work from latched copies
        cmd_valid = 1'b0;
        cmd_wr    = ~wr;
        cmd_sub   = ~sub;
        cmd_addr  = ~addr;
        cmd_wdata = ~wd;
    endtask

    task automatic wait_rsp(input string tag);
        int unsigned t = 0;
        while (rsp_cnt == b_rsp && t < 200) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        @(negedge clk);
        check(tag, rsp_cnt - b_rsp, 1);
    endtask

    task automatic run(input string tag, input logic wr, input logic [1:0] sub,
                       input logic [15:0] addr, input logic [7:0] wd);
        b_cyc = n_cyc;
        b_rsp = rsp_cnt;
        b_clk = act_clocks;
        issue(wr, sub, addr, wd);
        wait_rsp(tag);
    endtask

    int unsigned t;
    int unsigned lst;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", {31'd0, cmd_ready}, 1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_rsp_err", {31'd0, rsp_err}, 0);
        check("rst_rdata", {24'd0, rsp_rdata}, 8'h00);
        check("rst_addr", {16'd0, slt_a}, 16'h0000);
        check("rst_strobes", {29'd0, slt_sltsln, slt_rdn, slt_wen}, 3'b111);
        check("rst_d_hiz", {31'd0, slt_d === 8'hzz}, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // first read: select sequence from unknown shadow
        run("a_rsp", 1'b0, 2'd2, 16'h4000, 8'h00);
        check("a_ncyc", n_cyc - b_cyc, 3 + VER);
        check("a_clocks", act_clocks - b_clk, 4 * (3 + VER));
        check("a_c0", {15'd0, log_wr[b_cyc], log_addr[b_cyc]}, {1'b0, 16'hFFFF});
        check("a_c1", {7'd0, log_wr[b_cyc+1], log_addr[b_cyc+1], log_d[b_cyc+1]}, {1'b1, 16'hFFFF, 8'h08});
        check("a_c1_dstable", {31'd0, log_dst[b_cyc+1]}, 1);
        lst = b_cyc + 2 + VER;
        check("a_acc", {15'd0, log_wr[lst], log_addr[lst]}, {1'b0, 16'h4000});
        check("a_acc_len", log_len[lst], 4);
        check("a_acc_strb", log_strb[lst], 2);
        check("a_rdata", {23'd0, last_err, last_rdata}, {1'b0, 8'hE5});
        check("a_subreg", {24'd0, sub_reg}, 8'h08);
        if (VER == 1)
            check("a_verify", {15'd0, log_wr[b_cyc+2], log_addr[b_cyc+2]}, {1'b0, 16'hFFFF});

        // repeat read: shadow hit, access only
        run("b_rsp", 1'b0, 2'd2, 16'h4000, 8'h00);
        check("b_ncyc", n_cyc - b_cyc, 1);
        check("b_acc", {15'd0, log_wr[b_cyc], log_addr[b_cyc]}, {1'b0, 16'h4000});
        check("b_len", log_len[b_cyc], 4);
        check("b_rdata", {24'd0, last_rdata}, 8'hE5);

        // write to page 3 subslot 3
        run("c_rsp", 1'b1, 2'd3, 16'hC000, 8'h5A);
        check("c_ncyc", n_cyc - b_cyc, 2 + VER);
        check("c_sel", {7'd0, log_wr[b_cyc], log_addr[b_cyc], log_d[b_cyc]}, {1'b1, 16'hFFFF, 8'hC8});
        lst = b_cyc + 1 + VER;
        check("c_acc", {7'd0, log_wr[lst], log_addr[lst], log_d[lst]}, {1'b1, 16'hC000, 8'h5A});
        check("c_acc_dstable", {31'd0, log_dst[lst]}, 1);
        check("c_acc_len", log_len[lst], 4);
        check("c_model_wr", {8'd0, last_wa, last_wd}, {16'hC000, 8'h5A});
        check("c_err", {31'd0, last_err}, 0);

`ifdef EXT_SLT_HOST_VERIFY_EN
        // corrupted readback: error response, no access, next command re-reads
        corrupt = 1'b1;
        run("d_rsp", 1'b0, 2'd1, 16'h8000, 8'h00);
        check("d_ncyc", n_cyc - b_cyc, 2);
        check("d_sel", {7'd0, log_wr[b_cyc], log_addr[b_cyc], log_d[b_cyc]}, {1'b1, 16'hFFFF, 8'hD8});
        check("d_last_addr", {16'd0, log_addr[b_cyc+1]}, 16'hFFFF);
        check("d_err", {31'd0, last_err}, 1);
        corrupt = 1'b0;
        run("e_rsp", 1'b0, 2'd2, 16'h4000, 8'h00);
        check("e_ncyc", n_cyc - b_cyc, 2);
        check("e_c0", {15'd0, log_wr[b_cyc], log_addr[b_cyc]}, {1'b0, 16'hFFFF});
        check("e_rdata", {23'd0, last_err, last_rdata}, {1'b0, 8'hE5});
`endif

        // reset in the middle of a select write strobe
        b_rsp = rsp_cnt;
        issue(1'b0, 2'd0, 16'h4000, 8'h00);
        t = 0;
        while (!(slt_wen == 1'b0 && slt_a == 16'hFFFF) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("f_selwr_seen", {31'd0, slt_wen == 1'b0 && slt_a == 16'hFFFF}, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("f_rst_bus", {29'd0, slt_sltsln, slt_wen, slt_rdn}, 3'b111);
        check("f_rst_hiz", {31'd0, slt_d === 8'hzz}, 1);
        check("f_rst_addr", {16'd0, slt_a}, 16'h0000);
        check("f_rst_ctl", {30'd0, cmd_ready, rsp_valid}, 2'b10);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("f_no_rsp", rsp_cnt - b_rsp, 0);
        run("g_rsp", 1'b0, 2'd2, 16'h4000, 8'h00);
        check("g_c0", {15'd0, log_wr[b_cyc], log_addr[b_cyc]}, {1'b0, 16'hFFFF});
        check("g_rdata", {23'd0, last_err, last_rdata}, {1'b0, 8'hE5});

        // direct subslot-register access and shadow update
        run("h_rsp", 1'b1, 2'd0, 16'hFFFF, 8'hE4);
        check("h_ncyc", n_cyc - b_cyc, 1);
        check("h_wr", {7'd0, log_wr[b_cyc], log_addr[b_cyc], log_d[b_cyc]}, {1'b1, 16'hFFFF, 8'hE4});
        check("h_subreg", {24'd0, sub_reg}, 8'hE4);
        run("i_rsp", 1'b0, 2'd2, 16'h8000, 8'h00);
        check("i_ncyc", n_cyc - b_cyc, 1);
        check("i_acc", {15'd0, log_wr[b_cyc], log_addr[b_cyc]}, {1'b0, 16'h8000});
        check("i_rdata", {24'd0, last_rdata}, 8'h25);
        run("j_rsp", 1'b0, 2'd0, 16'hFFFF, 8'h00);
        check("j_ncyc", n_cyc - b_cyc, 1);
        check("j_rdata", {24'd0, last_rdata}, 8'h1B);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
